// File: rtl/conf_int_mac_dot_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : conf_int_mac_dot_seq_if
//  Brief    : Operand-in / result-out valid-ready bundle for the dot-product
//             sequencer. The slave modport is the sequencer side; the master
//             modport is the producer/consumer side.
//  Revision : 1.0  initial release
// ============================================================================
interface conf_int_mac_dot_seq_if #(
  parameter int DATA_PATH_BITWIDTH = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_PATH_BITWIDTH-1:0] a_in;
  logic [DATA_PATH_BITWIDTH-1:0] b_in;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_PATH_BITWIDTH-1:0] result;

  modport slave (
    input  in_valid,
    input  a_in,
    input  b_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result
  );

  modport master (
    output in_valid,
    output a_in,
    output b_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result
  );
endinterface
`default_nettype wire

// File: rtl/conf_int_mac_dot_seq.sv
`default_nettype none
// ============================================================================
//  Module   : conf_int_mac_dot_seq
//  Brief    : Sequences an external combinational MAC (d = a*b + c) through an
//             N-term dot product. Operands stream in over valid/ready, the
//             accumulator is fed back into the MAC's c input, and the
//             truncated sum leaves over a valid/ready result port.
//  Options  : CONF_INT_MAC_DOT_SEQ_BIAS_EN adds a 'bias' input that seeds the
//             accumulator when a start is accepted.
//  Revision : 1.0  initial release
// ============================================================================
module conf_int_mac_dot_seq #(
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int OP_BITWIDTH        = 16,
  parameter int LEN_BITWIDTH       = 8
) (
  input  logic                          clk,
  input  logic                          rst,      // asynchronous, active low
  input  logic                          start,
  input  logic [LEN_BITWIDTH-1:0]       len,
`ifdef CONF_INT_MAC_DOT_SEQ_BIAS_EN
  input  logic [DATA_PATH_BITWIDTH-1:0] bias,
`endif
  input  logic                          abort,
  conf_int_mac_dot_seq_if.slave         bus,
  output logic [DATA_PATH_BITWIDTH-1:0] mac_a,
  output logic [DATA_PATH_BITWIDTH-1:0] mac_b,
  output logic [DATA_PATH_BITWIDTH-1:0] mac_c,
  input  logic [DATA_PATH_BITWIDTH-1:0] mac_d,
  output logic                          busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [DATA_PATH_BITWIDTH-1:0]   acc_q,   acc_d;
  logic [LEN_BITWIDTH-1:0]         cnt_q,   cnt_d;
  logic [DATA_PATH_BITWIDTH-1:0]   acc_init;

  // OP_BITWIDTH belongs to the MAC; the operand ports here must be wide
  // enough to carry it. This block only exists in an invalid configuration.
  if (OP_BITWIDTH > DATA_PATH_BITWIDTH) begin : g_op_width_exceeds_path
  end

  // Seed value loaded into the accumulator when a start is accepted.
`ifdef CONF_INT_MAC_DOT_SEQ_BIAS_EN
  assign acc_init = bias;
`else
  assign acc_init = '0;
`endif

  // State, accumulator and term counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath update and all outputs; abort overrides everything.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.result    = '0;
    mac_a         = '0;
    mac_b         = '0;
    mac_c         = '0;
    busy          = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = acc_init;
          if (len != '0) begin
            cnt_d   = len;
            state_d = ST_ACC;
          end else begin
            state_d = ST_OUT;
          end
        end
      end

      ST_ACC: begin
        bus.in_ready = 1'b1;
        mac_a        = bus.a_in;
        mac_b        = bus.b_in;
        mac_c        = acc_q;
        if (bus.in_valid) begin
          acc_d = mac_d;
          cnt_d = cnt_q - LEN_BITWIDTH'(1);
          if (cnt_q == LEN_BITWIDTH'(1)) begin
            state_d = ST_OUT;
          end
        end
      end

      ST_OUT: begin
        bus.out_valid = 1'b1;
        bus.result    = acc_q;
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Cancel wins over start and over either handshake in the same cycle.
    if (abort) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conf_int_mac_dot_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conf_int_mac_dot_seq
//  Brief    : Directed self-checking bench for conf_int_mac_dot_seq. The MAC
//             is a behavioural d = a*b + c truncated to the datapath width.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conf_int_mac_dot_seq;

  localparam int W = 16;
  localparam int L = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [L-1:0] len = '0;
  logic         abort = 1'b0;
  logic [W-1:0] mac_a, mac_b, mac_c, mac_d;
  logic         busy;
`ifdef CONF_INT_MAC_DOT_SEQ_BIAS_EN
  logic [W-1:0] bias = '0;
`endif

  int checks = 0;
  int errors = 0;

  conf_int_mac_dot_seq_if #(.DATA_PATH_BITWIDTH(W)) bus ();

  conf_int_mac_dot_seq #(
    .DATA_PATH_BITWIDTH(W),
    .OP_BITWIDTH       (W),
    .LEN_BITWIDTH      (L)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .len   (len),
`ifdef CONF_INT_MAC_DOT_SEQ_BIAS_EN
    .bias  (bias),
`endif
    .abort (abort),
    .bus   (bus.slave),
    .mac_a (mac_a),
    .mac_b (mac_b),
    .mac_c (mac_c),
    .mac_d (mac_d),
    .busy  (busy)
  );

  // Behavioural combinational MAC, truncated to W bits.
  assign mac_d = W'(mac_a * mac_b + mac_c);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b0;

    // ---- reset then idle ----
    #22;
    check("rst_busy",      busy,          1'b0);
    check("rst_in_ready",  bus.in_ready,  1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    cyc(); rst = 1'b1;
    cyc(); cyc(); #1;
    check("idle_out_valid", bus.out_valid, 1'b0);
    check("idle_in_ready",  bus.in_ready,  1'b0);
    check("idle_busy",      busy,          1'b0);
    check("idle_result",    bus.result,    16'h0000);
    check("idle_mac_a",     mac_a,         16'h0000);

    // ---- basic dot product: 2*3 + 4*5 + 1*7 = 33 ----
    cyc(); start = 1'b1; len = 8'd3;
    cyc(); start = 1'b0; len = 8'd0;
    bus.in_valid = 1'b1; bus.a_in = 16'd2; bus.b_in = 16'd3; #1;
    check("dot_busy",     busy,         1'b1);
    check("dot_in_ready", bus.in_ready, 1'b1);
    check("dot_mac_a0",   mac_a,        16'd2);
    check("dot_mac_c0",   mac_c,        16'd0);
    cyc(); bus.a_in = 16'd4; bus.b_in = 16'd5; #1;
    check("dot_mac_c1",   mac_c,        16'd6);
    cyc(); bus.a_in = 16'd1; bus.b_in = 16'd7; #1;
    check("dot_mac_c2",   mac_c,        16'd26);
    check("dot_no_valid_yet", bus.out_valid, 1'b0);
    cyc(); bus.in_valid = 1'b0; #1;
    check("dot_out_valid", bus.out_valid, 1'b1);
    check("dot_result",    bus.result,    16'd33);
    check("dot_in_ready_out", bus.in_ready, 1'b0);
    check("dot_mac_c_out", mac_c,         16'd0);
    bus.out_ready = 1'b1;
    cyc(); bus.out_ready = 1'b0; #1;
    check("dot_idle_busy",  busy,          1'b0);
    check("dot_idle_valid", bus.out_valid, 1'b0);

    // ---- stall and backpressure: 0xFFFF*2 + 1*1 wraps to 0xFFFF ----
    cyc(); start = 1'b1; len = 8'd2;
    cyc(); start = 1'b0;
    bus.in_valid = 1'b1; bus.a_in = 16'hFFFF; bus.b_in = 16'd2;
    cyc(); bus.in_valid = 1'b0; #1;
    check("stall_acc_wrap", mac_c, 16'hFFFE);
    cyc(); #1;
    check("stall_in_ready", bus.in_ready,  1'b1);
    check("stall_no_valid", bus.out_valid, 1'b0);
    cyc(); bus.in_valid = 1'b1; bus.a_in = 16'd1; bus.b_in = 16'd1;
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.in_valid = 1'b0; #1;
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_result",    bus.result,    16'hFFFF);
    end
    bus.out_ready = 1'b1;
    cyc(); bus.out_ready = 1'b0; #1;
    check("bp_idle", busy, 1'b0);

    // ---- len = 0 ----
`ifdef CONF_INT_MAC_DOT_SEQ_BIAS_EN
    bias = 16'h0010;
`endif
    cyc(); start = 1'b1; len = 8'd0;
    cyc(); start = 1'b0; #1;
`ifdef CONF_INT_MAC_DOT_SEQ_BIAS_EN
    bias = 16'h0000;
    check("len0_result", bus.result, 16'h0010);
`else
    check("len0_result", bus.result, 16'h0000);
`endif
    check("len0_out_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    cyc(); bus.out_ready = 1'b0; #1;
    check("len0_idle", busy, 1'b0);

    // ---- abort with simultaneous start, then 3*3 = 9 ----
    cyc(); start = 1'b1; len = 8'd4;
    cyc(); start = 1'b0;
    bus.in_valid = 1'b1; bus.a_in = 16'd1; bus.b_in = 16'd1;
    cyc();
    cyc(); abort = 1'b1; start = 1'b1; len = 8'd1;
    cyc(); abort = 1'b0; start = 1'b0; bus.in_valid = 1'b0; #1;
    check("abort_busy",      busy,          1'b0);
    check("abort_in_ready",  bus.in_ready,  1'b0);
    check("abort_out_valid", bus.out_valid, 1'b0);
    cyc(); #1;
    check("abort_still_idle", busy, 1'b0);
    start = 1'b1; len = 8'd1;
    cyc(); start = 1'b0;
    bus.in_valid = 1'b1; bus.a_in = 16'd3; bus.b_in = 16'd3; #1;
    check("after_abort_mac_c", mac_c, 16'd0);
    cyc(); bus.in_valid = 1'b0; #1;
    check("after_abort_valid",  bus.out_valid, 1'b1);
    check("after_abort_result", bus.result,    16'd9);
    bus.out_ready = 1'b1;
    cyc(); bus.out_ready = 1'b0;

    // ---- asynchronous reset in the middle of accumulation ----
    cyc(); start = 1'b1; len = 8'd3;
    cyc(); start = 1'b0;
    bus.in_valid = 1'b1; bus.a_in = 16'd5; bus.b_in = 16'd5;
    cyc(); bus.in_valid = 1'b0; #1;
    check("mid_acc_c", mac_c, 16'd25);
    #2 rst = 1'b0; #1;
    check("arst_busy",      busy,          1'b0);
    check("arst_in_ready",  bus.in_ready,  1'b0);
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_mac_c",     mac_c,         16'd0);
    cyc(); rst = 1'b1;
    cyc(); #1;
    check("arst_idle_busy",   busy,       1'b0);
    check("arst_idle_result", bus.result, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Runaway guard.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/conf_int_mac_dot_seq.md
# conf_int_mac_dot_seq

Sequencer that drives one combinational `conf_int_mac__noFF__arch_agnos` instance (d = a*b + c) to compute an N-term dot product. It accepts operand pairs over a valid/ready stream and feeds the running accumulator back into the MAC's `c` input. It returns the truncated sum on a valid/ready result port. It sits between an operand producer (memory reader or upstream pipeline) and the MAC datapath, owning the MAC's inputs exclusively.

## Interface
- `DATA_PATH_BITWIDTH`, 16: width of operands, accumulator, MAC ports and result.
- `OP_BITWIDTH`, 16: operator bit width, passed unchanged to the MAC instance.
- `LEN_BITWIDTH`, 8: width of the term-count input.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new dot product; honoured only in IDLE.
- `len`  in  LEN_BITWIDTH  number of terms; sampled with `start`.
- `abort`  in  1  synchronous cancel of any in-flight operation.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  sequencer accepts operand pair.
- `a_in`, `b_in`  in  DATA_PATH_BITWIDTH each  operand pair.
- `mac_a`, `mac_b`, `mac_c`  out  DATA_PATH_BITWIDTH each  to MAC inputs a, b, c.
- `mac_d`  in  DATA_PATH_BITWIDTH  from MAC output d.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result.
- `result`  out  DATA_PATH_BITWIDTH  final accumulator value.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACC, OUT.
- IDLE:
  - `start`=1 with `len`≠0: load `cnt`←`len`, `acc`←0, go to ACC.
  - `start`=1 with `len`=0: `acc`←0, go to OUT.
- ACC:
  - `in_ready`=1.
  - Operand pair passes combinationally: `mac_a`=`a_in`, `mac_b`=`b_in`, `mac_c`=`acc`.
  - On each `in_valid & in_ready`: `acc`←`mac_d` and `cnt`←`cnt`−1. When `cnt` was 1, go to OUT.
- OUT:
  - `out_valid`=1 and `result`=`acc`, held stable until `out_ready`=1.
  - On handshake, go to IDLE.
- Arithmetic: all sums are modulo 2^DATA_PATH_BITWIDTH, matching the MAC's truncated output. No overflow indication.
- `mac_a`, `mac_b` and `mac_c` are driven 0 outside ACC.
- `in_ready`=0 outside ACC.
- `start` is ignored in ACC and OUT, with no queuing.
- `abort`=1 in any state: next state IDLE, `acc` and `cnt` cleared, result discarded. `abort` has priority over `start` and over both handshakes in the same cycle.
- `len` changes after `start` have no effect on the operation in progress.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, `acc`=0, `cnt`=0; `in_ready`=0, `out_valid`=0, `busy`=0, `result`=0, MAC inputs 0.
- `start` at edge k → ACC from cycle k+1, with `in_ready`=1 in that cycle.
- Throughput: one term per cycle while `in_valid` is held high.
- Latency: the last term is accepted at edge m → `out_valid`=1 in cycle m+1 (one cycle).
- Back-to-back: a result handshake at edge r → IDLE in cycle r+1; the earliest next `start` is accepted at edge r+1.
- Reset asserted mid-operation returns all state to reset values immediately, with no partial result emitted.

## Configuration
- `CONF_INT_MAC_DOT_SEQ_BIAS_EN`:
  - Defined: adds input port `bias` (DATA_PATH_BITWIDTH), sampled with an accepted `start`. `acc` is initialised to `bias` instead of 0. With `len`=0 the result equals `bias`.
  - Undefined: no `bias` port, and `acc` always starts at 0.

## Test plan
- Reset then idle: `rst` low then high, no stimulus → `out_valid`=0, `in_ready`=0, `busy`=0, `result`=0.
- Basic dot product: `len`=3; pairs (2,3), (4,5), (1,7) streamed back-to-back → `result`=33, `out_valid` one cycle after the third acceptance.
- Stall and backpressure: `len`=2; `in_valid` gapped two cycles between pairs (0xFFFF,2), (1,1); `out_ready` low for 3 cycles → wrapped `result`=0xFFFF, held stable until `out_ready`=1.
- `len`=0: `start` with `len`=0 → `out_valid` next cycle with `result`=0 (with macro and `bias`=0x0010, `result`=0x0010).
- Abort and ignored start: `len`=4, abort after 2 terms while `start`=1 is also asserted → IDLE next cycle, no `out_valid`. A later `start` with `len`=1 and pair (3,3) → `result`=9.
- Async reset mid-ACC: `rst` low after 1 of 3 terms → `busy`=0 and `in_ready`=0 without waiting for a clock edge.
